// File: rtl/i2c_txn_arbiter_pkg.sv
// ============================================================================
//  Module      : i2c_arb_pkg
//  Description : Shared types and widths for the I2C transaction arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_arb_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        LAUNCH = 3'd2,
        ACTIVE = 3'd3,
        DONE   = 3'd4,
        GAP    = 3'd5
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_txn_arbiter_if.sv
// ============================================================================
//  Module      : i2c_txn_arbiter_if
//  Description : Requester and I2C-master bundle seen by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int BAUD_W  = 2
);
    import i2c_arb_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*I2C_DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]            req_rw;
    logic [NUM_REQ*BAUD_W-1:0]     req_baud;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [I2C_DATA_W-1:0]         rsp_data;
    logic                          rsp_err;
    logic                          m_enable;
    logic                          m_rw;
    logic [I2C_ADDR_W-1:0]         m_addr;
    logic [I2C_DATA_W-1:0]         m_data_in;
    logic [BAUD_W-1:0]             m_baud_sel;
    logic [I2C_DATA_W-1:0]         m_data_out;
    logic                          m_busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, req_data, req_rw, req_baud, m_data_out, m_busy,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               m_enable, m_rw, m_addr, m_data_in, m_baud_sel
    );

    // Requesters plus the I2C master
    modport master (
        output req_valid, req_addr, req_data, req_rw, req_baud, m_data_out, m_busy,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               m_enable, m_rw, m_addr, m_data_in, m_baud_sel
    );

endinterface

`default_nettype wire

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin one-hot grant with a one-hot priority pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  wire logic               clk,
    input  wire logic               areset,
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic               advance,
    output logic      [NUM_REQ-1:0] grant
);

    logic [NUM_REQ-1:0]   r_ptr;
    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [2*NUM_REQ-1:0] w_masked;
    logic [2*NUM_REQ-1:0] w_first;

    // Doubled request vector: clearing bits below ptr and taking the lowest
    // survivor gives the first requester at or after ptr, with wrap-around.
    assign w_req_dbl = {req, req};
    assign w_masked  = w_req_dbl & ~({{NUM_REQ{1'b0}}, r_ptr} - (2*NUM_REQ)'(1));
    assign w_first   = w_masked & (~w_masked + (2*NUM_REQ)'(1));
    assign grant     = w_first[NUM_REQ-1:0] | w_first[2*NUM_REQ-1:NUM_REQ];

    always_ff @(posedge clk) begin
        if (areset) begin
            r_ptr <= {{(NUM_REQ-1){1'b0}}, 1'b1};
        end else if (advance && (|grant)) begin
            r_ptr <= {grant[NUM_REQ-2:0], grant[NUM_REQ-1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
// ============================================================================
//  Module      : i2c_txn_arbiter
//  Description : Round-robin transaction controller sharing one I2C master
//                between NUM_REQ requesters. Define I2C_ARB_TIMEOUT_EN to add
//                the busy watchdog (TIMEOUT_CYC) and the rsp_err flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int          NUM_REQ     = 3,
    parameter int          BAUD_W      = 2,
    parameter int unsigned GAP_CYC     = 50,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  wire logic        clk,
    input  wire logic        areset,
    i2c_txn_arbiter_if.slave bus
);

    arb_state_t            r_state;
    arb_state_t            w_next;
    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    r_owner;
    logic                  w_advance;
    logic                  w_timeout;
    logic                  w_rsp_rd;
    logic                  r_busy_q;
    logic [31:0]           r_gap;
    logic [I2C_ADDR_W-1:0] w_sel_addr;
    logic [I2C_ADDR_W-1:0] r_addr;
    logic [I2C_DATA_W-1:0] w_sel_data;
    logic [I2C_DATA_W-1:0] r_data;
    logic                  w_sel_rw;
    logic                  r_rw;
    logic [BAUD_W-1:0]     w_sel_baud;
    logic [BAUD_W-1:0]     r_baud;

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYC == 0 || TIMEOUT_CYC == 0) begin : g_param_check
        $error("i2c_txn_arbiter: parameter out of range");
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .areset  (areset),
        .req     (bus.req_valid),
        .advance (w_advance),
        .grant   (w_grant)
    );

    assign w_advance = (r_state == ARB) && (|w_grant);

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_rw   = 1'b0;
        w_sel_baud = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | bus.req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                w_sel_data = w_sel_data | bus.req_data[i*I2C_DATA_W +: I2C_DATA_W];
                w_sel_rw   = w_sel_rw   | bus.req_rw[i];
                w_sel_baud = w_sel_baud | bus.req_baud[i*BAUD_W +: BAUD_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|bus.req_valid) w_next = ARB;
            ARB:     w_next = (|w_grant) ? LAUNCH : IDLE;
            LAUNCH:  if (bus.m_busy) w_next = ACTIVE;
            ACTIVE:  if (r_busy_q && !bus.m_busy) w_next = DONE;
            DONE:    w_next = GAP;
            GAP:     if (r_gap == GAP_CYC - 1) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_timeout) begin
            w_next = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state  <= IDLE;
            r_busy_q <= 1'b0;
            r_gap    <= '0;
            r_owner  <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rw     <= 1'b0;
            r_baud   <= '0;
        end else begin
            r_state  <= w_next;
            r_busy_q <= bus.m_busy;
            r_gap    <= (r_state == GAP) ? r_gap + 32'd1 : 32'd0;
            // Master-facing fields only move here, so baud never changes mid-frame
            if (w_advance) begin
                r_owner <= w_grant;
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
                r_rw    <= w_sel_rw;
                r_baud  <= w_sel_baud;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_err;

    assign w_timeout = ((r_state == LAUNCH) || (r_state == ACTIVE)) &&
                       (r_wdog == TIMEOUT_CYC - 1);

    always_ff @(posedge clk) begin
        if (areset) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if ((w_next != r_state) && ((w_next == LAUNCH) || (w_next == ACTIVE))) begin
                r_wdog <= '0;
            end else if ((r_state == LAUNCH) || (r_state == ACTIVE)) begin
                r_wdog <= r_wdog + 32'd1;
            end
            if (w_advance) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = (r_state == DONE) & r_err;
    assign w_rsp_rd    = r_rw & ~r_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.rsp_err = 1'b0;
    assign w_rsp_rd    = r_rw;
`endif

    assign bus.req_ready  = (r_state == ARB) ? w_grant : '0;
    assign bus.rsp_valid  = (r_state == DONE) ? r_owner : '0;
    assign bus.rsp_data   = ((r_state == DONE) && w_rsp_rd) ? bus.m_data_out : '0;
    assign bus.m_enable   = (r_state == LAUNCH) & ~w_timeout;
    assign bus.m_rw       = r_rw;
    assign bus.m_addr     = r_addr;
    assign bus.m_data_in  = r_data;
    assign bus.m_baud_sel = r_baud;

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
// ============================================================================
//  Module      : tb_i2c_txn_arbiter
//  Description : Directed bench for i2c_txn_arbiter with a behavioural master.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_txn_arbiter;

    localparam int          NUM_REQ = 3;
    localparam int          BAUD_W  = 2;
    localparam int unsigned GAP_CYC = 50;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = 100;
`else
    localparam int unsigned TIMEOUT_CYC = 200000;
`endif

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NUM_REQ(NUM_REQ), .BAUD_W(BAUD_W)) bus ();

    i2c_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .BAUD_W      (BAUD_W),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic [7:0] data;
        logic       rw;
        logic [1:0] baud;
        logic [7:0] exp_data;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural I2C master
    logic [7:0] mem [0:127];
    logic       stall = 1'b0;
    int         busy_cnt, busy_start, fall_cyc, last_len;
    logic [6:0] cap_addr;
    logic [7:0] cap_data;
    logic       cap_rw;

    // Requester-side copies of what was offered
    logic [6:0] s_addr [NUM_REQ];
    logic [7:0] s_data [NUM_REQ];
    logic       s_rw   [NUM_REQ];
    logic [1:0] s_baud [NUM_REQ];

    // Event logs
    int         g_n, l_n, r_n;
    int         g_idx [64];
    int         g_cyc [64];
    int         l_cyc [64];
    int         r_idx [64];
    int         r_cyc [64];
    int         r_fall[64];
    int         r_len [64];
    logic [7:0] r_data[64];
    logic       r_err [64];
    logic       r_en  [64];

    logic [NUM_REQ-1:0] drop_q = '0;
    logic               prev_en = 1'b0;
    logic               prev_ready = 1'b0;
    logic [BAUD_W-1:0]  prev_baud = '0;

    function automatic int oh_idx(logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ge(string name, int act, int min);
        n_cmp++;
        if (act < min) begin
            n_err++;
            $display("FAIL %s: got %0d, required >= %0d", name, act, min);
        end
    endtask

    task automatic clear_logs();
        g_n = 0; l_n = 0; r_n = 0;
    endtask

    task automatic set_req(int i, logic [6:0] a, logic [7:0] d, logic rw, logic [1:0] b);
        s_addr[i] = a; s_data[i] = d; s_rw[i] = rw; s_baud[i] = b;
        bus.req_addr[i*7 +: 7]           = a;
        bus.req_data[i*8 +: 8]           = d;
        bus.req_rw[i]                    = rw;
        bus.req_baud[i*BAUD_W +: BAUD_W] = b;
    endtask

    // One clock: sample DUT, log events, withdraw granted requests, run master model
    task automatic tick();
        int g;
        @(posedge clk);
        #1;
        cyc++;
        if (drop_q != '0) begin
            g = oh_idx(drop_q);
            check("m_addr_latched",  32'(bus.m_addr),     32'(s_addr[g]));
            check("m_data_latched",  32'(bus.m_data_in),  32'(s_data[g]));
            check("m_rw_latched",    32'(bus.m_rw),       32'(s_rw[g]));
            check("m_baud_latched",  32'(bus.m_baud_sel), 32'(s_baud[g]));
            check("m_enable_launch", 32'(bus.m_enable),   32'd1);
            bus.req_valid = bus.req_valid & ~drop_q;
            drop_q = '0;
        end
        if (bus.m_enable && !prev_en) begin
            l_cyc[l_n] = cyc; l_n++;
        end
        if (bus.req_ready != '0) begin
            g_idx[g_n] = oh_idx(bus.req_ready); g_cyc[g_n] = cyc; g_n++;
            drop_q = bus.req_ready;
        end
        if (bus.rsp_valid != '0) begin
            r_idx[r_n]  = oh_idx(bus.rsp_valid);
            r_cyc[r_n]  = cyc;
            r_fall[r_n] = fall_cyc;
            r_len[r_n]  = last_len;
            r_data[r_n] = bus.rsp_data;
            r_err[r_n]  = bus.rsp_err;
            r_en[r_n]   = bus.m_enable;
            r_n++;
        end
        if (!areset && (bus.m_baud_sel != prev_baud))
            check("baud_change_after_arb", 32'(prev_ready), 32'd1);
        prev_ready = (bus.req_ready != '0);
        prev_baud  = bus.m_baud_sel;
        prev_en    = bus.m_enable;

        if (areset) begin
            bus.m_busy = 1'b0;
            busy_cnt   = 0;
        end else if (bus.m_busy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                bus.m_busy = 1'b0;
                fall_cyc   = cyc;
                last_len   = cyc - busy_start;
                if (cap_rw) bus.m_data_out = mem[cap_addr];
                else        mem[cap_addr]  = cap_data;
            end
        end else if (bus.m_enable && !stall) begin
            bus.m_busy = 1'b1;
            busy_cnt   = 6 * (int'(bus.m_baud_sel) + 1);
            busy_start = cyc;
            cap_addr   = bus.m_addr;
            cap_data   = bus.m_data_in;
            cap_rw     = bus.m_rw;
        end
    endtask

    task automatic wait_rsp(int target, int bound, string name);
        int k = 0;
        while (r_n < target && k < bound) begin
            tick();
            k++;
        end
        if (r_n < target) begin
            n_cmp++; n_err++;
            $display("FAIL %s: got %0d responses, required %0d within %0d cycles", name, r_n, target, bound);
        end
    endtask

    task automatic do_reset();
        areset = 1'b1;
        bus.req_valid = '0;
        drop_q = '0;
        tick();
        tick();
        areset = 1'b0;
        clear_logs();
    endtask

    vec_t vecs [6];

    initial begin
        int base, gbase, raise_cyc, k;

        vecs[0] = '{0, 7'h57, 8'hAA, 1'b0, 2'd0, 8'h00};
        vecs[1] = '{2, 7'h58, 8'hF0, 1'b0, 2'd2, 8'h00};
        vecs[2] = '{1, 7'h58, 8'h00, 1'b1, 2'd1, 8'hF0};
        vecs[3] = '{0, 7'h57, 8'h11, 1'b1, 2'd0, 8'hAA};
        vecs[4] = '{2, 7'h10, 8'h00, 1'b1, 2'd3, 8'h2C};
        vecs[5] = '{1, 7'h7F, 8'h00, 1'b0, 2'd1, 8'h00};

        for (int a = 0; a < 128; a++) mem[a] = 8'(a) ^ 8'h3C;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.req_rw = '0; bus.req_baud = '0; bus.m_data_out = '0; bus.m_busy = 1'b0;
        busy_cnt = 0; busy_start = 0; fall_cyc = 0; last_len = 0;
        areset = 1'b1;
        tick();
        check("reset_req_ready",  32'(bus.req_ready),  32'd0);
        check("reset_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("reset_m_enable",   32'(bus.m_enable),   32'd0);
        check("reset_m_addr",     32'(bus.m_addr),     32'd0);
        check("reset_m_baud_sel", 32'(bus.m_baud_sel), 32'd0);
        do_reset();

        // Table-driven single-requester transactions
        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].idx, vecs[v].addr, vecs[v].data, vecs[v].rw, vecs[v].baud);
            bus.req_valid[vecs[v].idx] = 1'b1;
            raise_cyc = cyc;
            base  = r_n;
            gbase = g_n;
            wait_rsp(base + 1, 2000, "vec_rsp");
            if (r_n > base) begin
                check("vec_grant",     32'(g_idx[gbase]),  32'(vecs[v].idx));
                check("vec_rsp_owner", 32'(r_idx[base]),   32'(vecs[v].idx));
                check("vec_rsp_data",  32'(r_data[base]),  32'(vecs[v].exp_data));
                check("vec_rsp_err",   32'(r_err[base]),   32'd0);
                check("vec_rsp_lat",   32'(r_cyc[base] - r_fall[base]), 32'd1);
                if (v == 0) begin
                    check("lat_req_ready", 32'(g_cyc[0] - raise_cyc), 32'd1);
                    check("lat_m_enable",  32'(l_cyc[0] - raise_cyc), 32'd2);
                end
            end
        end
        check("scl_period_differs", 32'(r_len[0] != r_len[1]), 32'd1);

        // Contention: all three at once, twice
        for (int burst = 0; burst < 2; burst++) begin
            if (burst == 0) do_reset();
            else clear_logs();
            set_req(0, 7'h20, 8'h01, 1'b0, 2'd0);
            set_req(1, 7'h21, 8'h02, 1'b0, 2'd1);
            set_req(2, 7'h22, 8'h03, 1'b0, 2'd2);
            bus.req_valid = 3'b111;
            wait_rsp(3, 1500, "burst_rsp");
            if (r_n >= 3) begin
                for (int j = 0; j < 3; j++) begin
                    check("burst_grant_order", 32'(g_idx[j]), 32'(j));
                    check("burst_rsp_owner",   32'(r_idx[j]), 32'(j));
                end
                for (int j = 0; j < 2; j++) begin
                    check_ge("burst_grant_spacing", g_cyc[j+1] - g_cyc[j], int'(GAP_CYC) + 2);
                    check_ge("burst_rsp_to_enable", l_cyc[j+1] - r_cyc[j], int'(GAP_CYC) + 2);
                end
            end
        end

        // Reset while ACTIVE, with ptr advanced past requester 1
        do_reset();
        set_req(1, 7'h33, 8'h44, 1'b0, 2'd1);
        bus.req_valid[1] = 1'b1;
        k = 0;
        while (!(g_n > 0 && bus.m_busy === 1'b1 && bus.m_enable === 1'b0) && k < 200) begin
            tick();
            k++;
        end
        check("reach_active", 32'(k < 200), 32'd1);
        areset = 1'b1;
        tick();
        check("rst_req_ready",  32'(bus.req_ready),  32'd0);
        check("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        check("rst_rsp_data",   32'(bus.rsp_data),   32'd0);
        check("rst_rsp_err",    32'(bus.rsp_err),    32'd0);
        check("rst_m_enable",   32'(bus.m_enable),   32'd0);
        check("rst_m_rw",       32'(bus.m_rw),       32'd0);
        check("rst_m_addr",     32'(bus.m_addr),     32'd0);
        check("rst_m_data_in",  32'(bus.m_data_in),  32'd0);
        check("rst_m_baud_sel", 32'(bus.m_baud_sel), 32'd0);
        areset = 1'b0;
        clear_logs();
        repeat (20) tick();
        check("rst_no_rsp", 32'(r_n), 32'd0);
        set_req(0, 7'h40, 8'h55, 1'b0, 2'd0);
        set_req(2, 7'h41, 8'h66, 1'b0, 2'd0);
        bus.req_valid = 3'b101;
        wait_rsp(2, 1000, "post_reset_rsp");
        if (g_n > 0) check("post_reset_grant", 32'(g_idx[0]), 32'd0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: master never raises busy
        do_reset();
        stall = 1'b1;
        set_req(0, 7'h50, 8'h00, 1'b1, 2'd0);
        bus.req_valid[0] = 1'b1;
        wait_rsp(1, 500, "timeout_rsp");
        if (r_n > 0 && l_n > 0) begin
            check("timeout_err",    32'(r_err[0]),  32'd1);
            check("timeout_data",   32'(r_data[0]), 32'd0);
            check("timeout_enable", 32'(r_en[0]),   32'd0);
            check("timeout_cycle",  32'(r_cyc[0] - l_cyc[0]), 32'(TIMEOUT_CYC));
        end
        stall = 1'b0;
`endif

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded 50000 cycles, required to finish earlier");
        $fatal(1, "bench watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin transaction controller that shares the single multi-baud I2C master (`i2c_top_multi`) between `NUM_REQ` independent requesters. It latches one complete request (slave address, write byte, R/W, baud selector) and drives the master's `enable`/`addr`/`data_in`/`rw` and baud-select inputs. It tracks the master's `busy` handshake and returns the read byte and completion status to the granted requester. Baud changes are applied only between transactions, never mid-frame.

## Interface
- `NUM_REQ`, default 3: number of requesters (2..8).
- `BAUD_W`, default 2: width of the baud selector.
- `GAP_CYC`, default 50: idle cycles forced between consecutive transactions.
- `TIMEOUT_CYC`, default 200000: busy watchdog limit. Used only with `I2C_ARB_TIMEOUT_EN`.
- `clk`, in, 1: single clock.
- `areset`, in, 1: reset; synchronous, active-high.
- `req_valid`, in, NUM_REQ: per-requester request.
- `req_ready`, out, NUM_REQ: one-hot grant pulse; the request is accepted in that cycle.
- `req_addr`, in, NUM_REQ*7: packed 7-bit slave addresses; requester i occupies bits [7i+6:7i].
- `req_data`, in, NUM_REQ*8: packed write bytes.
- `req_rw`, in, NUM_REQ: 1 = read, 0 = write.
- `req_baud`, in, NUM_REQ*BAUD_W: packed baud selectors.
- `rsp_valid`, out, NUM_REQ: one-hot, one-cycle completion pulse to the owning requester.
- `rsp_data`, out, 8: read byte; valid while `rsp_valid` is nonzero.
- `rsp_err`, out, 1: watchdog timeout flag; valid with `rsp_valid`.
- `m_enable`, `m_rw`, out, 1 each: to the master.
- `m_addr`, out, 7: to the master.
- `m_data_in`, out, 8: to the master.
- `m_baud_sel`, out, BAUD_W: to the master.
- `m_data_out`, in, 8: read data from the master.
- `m_busy`, in, 1: busy from the master.

## Operation
- FSM states: IDLE, ARB, LAUNCH, ACTIVE, DONE, GAP.
- **IDLE:** when any `req_valid` is high, go to ARB.
- **ARB (1 cycle):**
  - Grant the first valid requester starting at `ptr` and wrapping modulo NUM_REQ.
  - Pulse `req_ready[g]`.
  - Latch addr, data, rw and baud into the `m_*` registers.
  - Set `ptr = g+1` (mod NUM_REQ).
  - Go to LAUNCH.
  - If no request is valid, return to IDLE.
- **LAUNCH:** `m_enable`=1. On the first cycle `m_busy`=1, drop `m_enable` and go to ACTIVE.
- **ACTIVE:** `m_enable`=0. On `m_busy` falling (registered edge detect), go to DONE.
- **DONE (1 cycle):**
  - `rsp_valid[g]`=1.
  - `rsp_data` = `m_data_out` when rw=1, otherwise 0x00.
  - `rsp_err` is set per watchdog.
  - Go to GAP.
- **GAP:** count GAP_CYC cycles, then go to IDLE.
- **Baud selector:** `m_baud_sel`, `m_addr`, `m_data_in` and `m_rw` change only in ARB and are held stable through LAUNCH, ACTIVE, DONE and GAP.
- **Request rules:**
  - Requesters keep `req_valid` high until `req_ready`.
  - Dropping `req_valid` before grant withdraws the request.
  - `req_valid` seen during DONE or GAP is served at the next ARB.
- **Simultaneous requests:** resolved strictly round-robin, so no requester waits more than NUM_REQ-1 transactions.

## Timing
- **Reset values:**
  - All outputs 0.
  - `ptr`=0.
  - State IDLE.
  - Watchdog counter 0.
- **Reset mid-transaction:** takes effect the next clock. `m_enable` drops, no `rsp_valid` is issued, and the in-flight request is lost. The master shares `areset`.
- **Latency:** `req_valid` high in IDLE leads to `req_ready` 1 cycle later and `m_enable` 2 cycles later. `rsp_valid` is 1 cycle after `m_busy` is sampled low in ACTIVE.
- **Back-to-back spacing:** minimum GAP_CYC+2 cycles between successive `rsp_valid` edges and the next `m_enable` rise.

## Configuration
- **With `I2C_ARB_TIMEOUT_EN` defined:** a 32-bit counter restarts on entry to LAUNCH and to ACTIVE. If it reaches TIMEOUT_CYC in either state:
  - Force `m_enable`=0.
  - Go to DONE with `rsp_err`=1 and `rsp_data`=0x00.
- **Without it:** the FSM waits indefinitely, `rsp_err` is tied to 0, and no counter is synthesized.

## Structure
- Package `i2c_arb_pkg`:
  - State enum `arb_state_t`.
  - Constants `I2C_ADDR_W`=7 and `I2C_DATA_W`=8.
- Sub-module `rr_arbiter`:
  - Owns the NUM_REQ-wide pointer register.
  - Inputs: request vector and an advance strobe.
  - Output: one-hot grant.

## Test plan
- **Single write:** requester 0 sends addr 7'h57, data 8'hAA, rw 0, baud 0. Expect:
  - Master sees addr 7'h57 W with ACK.
  - `rsp_valid`=3'b001, `rsp_data`=0x00, `rsp_err`=0.
- **Read:** requester 1 sends addr 7'h58, rw 1, after a prior write of 8'hF0. Expect `rsp_valid`=3'b010 and `rsp_data`=8'hF0.
- **Contention:** all three requesters raise `req_valid` in the same cycle after reset. Expect:
  - Grants in order 0,1,2.
  - Each separated by at least GAP_CYC+2 cycles.
  - A repeat burst grants in order 0,1,2 again.
- **Baud change:** requester 2 uses baud 2 while requester 0 uses baud 0. Expect:
  - `m_baud_sel` changes only in ARB cycles.
  - The SCL period differs per transaction.
  - Both transactions ACK.
- **Timeout (macro on, TIMEOUT_CYC=100):** tie `m_busy`=0. Expect `rsp_valid` with `rsp_err`=1 on the 101st cycle after LAUNCH entry, and `m_enable` low.
- **Reset in ACTIVE:** assert `areset` for 1 cycle. Expect:
  - All outputs 0 the next cycle.
  - No `rsp_valid`.
  - The next request is granted to requester 0.
